// File: rtl/rv_pkg.sv
// Shared rv32i types and constants used by the pipeline-side blocks.
// Holds the memory-arbiter state encoding and its sizing helper.
package rv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_IF,
        ADDR_MEM,
        DATA_IF,
        DATA_MEM
    } arb_state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Eight bits covers the default limit; wider limits grow the counter.
    function automatic int arb_cnt_width(input int unsigned limit);
        return (limit > 255) ? $clog2(limit + 1) : 8;
    endfunction

endpackage

// File: rtl/rv_mem_arbiter.sv
// Single-port memory bus arbiter between IF (fetch) and MEM (load/store).
// MEM wins ties; flushed fetches are drained silently; data phases time out.
module rv_mem_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_arb_if_req,
    input  logic [31:0] i_arb_if_addr,
    input  logic        i_arb_if_flush,
    output logic        o_arb_if_rvalid,
    output logic [31:0] o_arb_if_rdata,
    output logic        o_arb_stall_if,
    input  logic        i_arb_mem_req,
    input  logic        i_arb_mem_we,
    input  logic [31:0] i_arb_mem_addr,
    input  logic [31:0] i_arb_mem_wdata,
    input  logic [3:0]  i_arb_mem_be,
    output logic        o_arb_mem_rvalid,
    output logic [31:0] o_arb_mem_rdata,
    output logic        o_arb_stall_mem,
    output logic        o_arb_bus_req,
    output logic        o_arb_bus_we,
    output logic [31:0] o_arb_bus_addr,
    output logic [31:0] o_arb_bus_wdata,
    output logic [3:0]  o_arb_bus_be,
    input  logic        i_arb_bus_gnt,
    input  logic        i_arb_bus_rvalid,
    input  logic [31:0] i_arb_bus_rdata,
    output logic        o_arb_timeout
);

    localparam int CNT_W = arb_cnt_width(TIMEOUT_CYC);
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    arb_state_e       state;
    arb_state_e       state_nx;
    logic             drop;
    logic             drop_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    logic in_addr;
    logic in_data;
    logic in_fetch;
    logic tmo;
    logic done;
    logic load_mem;
    logic load_if;
    logic if_kill;

    always_comb begin
        in_addr  = (state == ADDR_IF) || (state == ADDR_MEM);
        in_data  = (state == DATA_IF) || (state == DATA_MEM);
        in_fetch = (state == ADDR_IF) || (state == DATA_IF);
        // The limit-th data cycle fires when the count is one short of it.
        tmo      = TMO_EN && in_data && !i_arb_bus_rvalid
                   && (cnt == CNT_LAST);
        done     = in_data && (i_arb_bus_rvalid || tmo);
        if_kill  = drop || i_arb_if_flush;
    end

    always_comb begin
        state_nx = state;
        load_mem = 1'b0;
        load_if  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_arb_mem_req) begin
                    load_mem = 1'b1;
                    state_nx = ADDR_MEM;
                end else if (i_arb_if_req && !i_arb_if_flush) begin
                    load_if  = 1'b1;
                    state_nx = ADDR_IF;
                end
            end
            ADDR_IF: begin
                if (i_arb_bus_gnt) state_nx = DATA_IF;
            end
            ADDR_MEM: begin
                if (i_arb_bus_gnt) state_nx = DATA_MEM;
            end
            DATA_IF, DATA_MEM: begin
                if (done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        drop_nx = drop;
        if (state == IDLE || done) begin
            drop_nx = 1'b0;
        end else if (in_fetch && i_arb_if_flush) begin
            drop_nx = 1'b1;
        end
    end

    always_comb begin
        cnt_nx = cnt;
        if (in_addr && i_arb_bus_gnt) begin
            cnt_nx = '0;
        end else if (done) begin
            cnt_nx = '0;
        end else if (in_data) begin
            cnt_nx = cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            drop  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            drop  <= drop_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_arb_bus_we    <= 1'b0;
            o_arb_bus_addr  <= '0;
            o_arb_bus_wdata <= '0;
            o_arb_bus_be    <= '0;
        end else if (load_mem) begin
            o_arb_bus_we    <= i_arb_mem_we;
            o_arb_bus_addr  <= i_arb_mem_addr;
            o_arb_bus_wdata <= i_arb_mem_wdata;
            o_arb_bus_be    <= i_arb_mem_be;
        end else if (load_if) begin
            o_arb_bus_we    <= 1'b0;
            o_arb_bus_addr  <= i_arb_if_addr;
            o_arb_bus_wdata <= '0;
            o_arb_bus_be    <= BE_WORD;
        end
    end

    always_comb begin
        o_arb_bus_req    = in_addr;
        o_arb_timeout    = tmo;
        o_arb_mem_rvalid = (state == DATA_MEM) && done;
        o_arb_mem_rdata  = '0;
        if (o_arb_mem_rvalid && !tmo && !o_arb_bus_we) begin
            o_arb_mem_rdata = i_arb_bus_rdata;
        end
        // A killed fetch still drains on the bus but is never forwarded.
        o_arb_if_rvalid  = (state == DATA_IF) && done && !if_kill;
        o_arb_if_rdata   = '0;
        if (o_arb_if_rvalid && !tmo) begin
            o_arb_if_rdata = i_arb_bus_rdata;
        end
        o_arb_stall_if   = i_arb_if_req && !o_arb_if_rvalid;
        o_arb_stall_mem  = i_arb_mem_req && !o_arb_mem_rvalid;
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a hand-driven bus.
// Timeout limit is 4 so the timeout case is short.
module tb_rv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        stall_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        timeout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv_mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_arb_if_req    (if_req),
        .i_arb_if_addr   (if_addr),
        .i_arb_if_flush  (if_flush),
        .o_arb_if_rvalid (if_rvalid),
        .o_arb_if_rdata  (if_rdata),
        .o_arb_stall_if  (stall_if),
        .i_arb_mem_req   (mem_req),
        .i_arb_mem_we    (mem_we),
        .i_arb_mem_addr  (mem_addr),
        .i_arb_mem_wdata (mem_wdata),
        .i_arb_mem_be    (mem_be),
        .o_arb_mem_rvalid(mem_rvalid),
        .o_arb_mem_rdata (mem_rdata),
        .o_arb_stall_mem (stall_mem),
        .o_arb_bus_req   (bus_req),
        .o_arb_bus_we    (bus_we),
        .o_arb_bus_addr  (bus_addr),
        .o_arb_bus_wdata (bus_wdata),
        .o_arb_bus_be    (bus_be),
        .i_arb_bus_gnt   (bus_gnt),
        .i_arb_bus_rvalid(bus_rvalid),
        .i_arb_bus_rdata (bus_rdata),
        .o_arb_timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to the next cycle: inputs change at negedge, outputs read 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        if_flush   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_req"},  32'(bus_req), 0);
        chk({tag, "_bus_we"},   32'(bus_we), 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wdat"}, bus_wdata, 0);
        chk({tag, "_bus_be"},   32'(bus_be), 0);
        chk({tag, "_if_rv"},    32'(if_rvalid), 0);
        chk({tag, "_mem_rv"},   32'(mem_rvalid), 0);
        chk({tag, "_mem_rd"},   mem_rdata, 0);
        chk({tag, "_tmo"},      32'(timeout), 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        settle();
        chk_all_zero("rst0");
        step();
        rst = 1'b0;

        // IF-only fetch, zero-wait bus
        step();
        if_req = 1'b1;
        if_addr = 32'h100;
        settle();
        chk("f1_c0_stall", 32'(stall_if), 1);
        chk("f1_c0_req", 32'(bus_req), 0);
        step();
        bus_gnt = 1'b1;
        settle();
        chk("f1_c1_req", 32'(bus_req), 1);
        chk("f1_c1_addr", bus_addr, 32'h100);
        chk("f1_c1_be", 32'(bus_be), 32'hF);
        chk("f1_c1_we", 32'(bus_we), 0);
        chk("f1_c1_stall", 32'(stall_if), 1);
        step();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h00500093;
        settle();
        chk("f1_c2_rv", 32'(if_rvalid), 1);
        chk("f1_c2_rd", if_rdata, 32'h00500093);
        chk("f1_c2_stall", 32'(stall_if), 0);
        step();
        idle_inputs();
        settle();
        chk("f1_c3_rv", 32'(if_rvalid), 0);
        chk("f1_c3_req", 32'(bus_req), 0);

        // Simultaneous IF fetch and MEM store: store first
        step();
        if_req = 1'b1;
        if_addr = 32'h104;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h2000;
        mem_wdata = 32'hDEADBEEF;
        mem_be = 4'b0011;
        settle();
        chk("p_c0_stif", 32'(stall_if), 1);
        chk("p_c0_stmem", 32'(stall_mem), 1);
        step();
        bus_gnt = 1'b1;
        settle();
        chk("p_c1_req", 32'(bus_req), 1);
        chk("p_c1_we", 32'(bus_we), 1);
        chk("p_c1_addr", bus_addr, 32'h2000);
        chk("p_c1_wdat", bus_wdata, 32'hDEADBEEF);
        chk("p_c1_be", 32'(bus_be), 32'h3);
        step();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        settle();
        chk("p_c2_mrv", 32'(mem_rvalid), 1);
        chk("p_c2_mrd", mem_rdata, 0);
        chk("p_c2_irv", 32'(if_rvalid), 0);
        chk("p_c2_stmem", 32'(stall_mem), 0);
        chk("p_c2_stif", 32'(stall_if), 1);
        step();
        mem_req = 1'b0;
        mem_we = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        settle();
        chk("p_c3_req", 32'(bus_req), 0);
        chk("p_c3_stif", 32'(stall_if), 1);
        step();
        bus_gnt = 1'b1;
        settle();
        chk("p_c4_req", 32'(bus_req), 1);
        chk("p_c4_addr", bus_addr, 32'h104);
        chk("p_c4_we", 32'(bus_we), 0);
        chk("p_c4_be", 32'(bus_be), 32'hF);
        step();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h00000013;
        settle();
        chk("p_c5_irv", 32'(if_rvalid), 1);
        chk("p_c5_ird", if_rdata, 32'h00000013);
        step();
        idle_inputs();

        // Load with gnt delayed three cycles
        step();
        mem_req = 1'b1;
        mem_addr = 32'h3000;
        mem_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            bus_gnt = (i == 3);
            settle();
            chk($sformatf("g_a%0d_req", i), 32'(bus_req), 1);
            chk($sformatf("g_a%0d_addr", i), bus_addr, 32'h3000);
            chk($sformatf("g_a%0d_be", i), 32'(bus_be), 32'hF);
            chk($sformatf("g_a%0d_mrv", i), 32'(mem_rvalid), 0);
        end
        step();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h12345678;
        settle();
        chk("g_d_mrv", 32'(mem_rvalid), 1);
        chk("g_d_mrd", mem_rdata, 32'h12345678);
        chk("g_d_req", 32'(bus_req), 0);
        step();
        idle_inputs();

        // Flush during DATA_IF, then a fresh fetch at 0x200
        step();
        if_req = 1'b1;
        if_addr = 32'h180;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        if_flush = 1'b1;
        if_req = 1'b0;
        settle();
        chk("fl_c2_irv", 32'(if_rvalid), 0);
        step();
        if_flush = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h200;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h00000BAD;
        settle();
        chk("fl_c3_irv", 32'(if_rvalid), 0);
        chk("fl_c3_ird", if_rdata, 0);
        chk("fl_c3_stif", 32'(stall_if), 1);
        step();
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        settle();
        chk("fl_c4_req", 32'(bus_req), 0);
        step();
        bus_gnt = 1'b1;
        settle();
        chk("fl_c5_req", 32'(bus_req), 1);
        chk("fl_c5_addr", bus_addr, 32'h200);
        step();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h00000297;
        settle();
        chk("fl_c6_irv", 32'(if_rvalid), 1);
        chk("fl_c6_ird", if_rdata, 32'h00000297);
        step();
        idle_inputs();

        // Bus never answers: timeout on the 4th data cycle
        step();
        mem_req = 1'b1;
        mem_addr = 32'h4000;
        mem_be = 4'hF;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        bus_rdata = 32'h55555555;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) step();
            settle();
            chk($sformatf("t_d%0d_tmo", i), 32'(timeout), 32'(i == 4));
            chk($sformatf("t_d%0d_mrv", i), 32'(mem_rvalid), 32'(i == 4));
            chk($sformatf("t_d%0d_st", i), 32'(stall_mem), 32'(i != 4));
            chk($sformatf("t_d%0d_mrd", i), mem_rdata, 0);
        end
        step();
        idle_inputs();
        settle();
        chk("t_after_tmo", 32'(timeout), 0);
        chk("t_after_req", 32'(bus_req), 0);

        // Reset asserted while in DATA_MEM
        step();
        mem_req = 1'b1;
        mem_addr = 32'h5000;
        mem_be = 4'hF;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        rst = 1'b1;
        mem_req = 1'b0;
        settle();
        chk_all_zero("r_in");
        step();
        bus_rvalid = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        settle();
        chk_all_zero("r_hold");
        step();
        rst = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("r_post%0d_mrv", i), 32'(mem_rvalid), 0);
            chk($sformatf("r_post%0d_req", i), 32'(bus_req), 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Shares one single-ported memory bus between the IF stage (instruction fetch) and the MEM stage (load/store) of the rv32i pipeline. The MEM stage has priority. Each access is registered into the bus, and the read data or write acknowledge is routed back to the owner. While an owner's access is incomplete, the block raises that owner's stall. It also discards fetch responses invalidated by a branch/jump flush, and bounds every bus transaction with a timeout.

## Interface
Parameters:
- TIMEOUT_CYC, 255, maximum cycles spent in a data phase before forced completion; 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_arb_if_req  in  1  fetch request; held until o_arb_if_rvalid or i_arb_if_flush.
- i_arb_if_addr  in  32  fetch address.
- i_arb_if_flush  in  1  kill the current fetch (taken branch/jump).
- o_arb_if_rvalid  out  1  fetch data valid (one-cycle pulse).
- o_arb_if_rdata  out  32  instruction word.
- o_arb_stall_if  out  1  i_arb_if_req && !o_arb_if_rvalid.
- i_arb_mem_req  in  1  data request; held until o_arb_mem_rvalid.
- i_arb_mem_we  in  1  1 = store.
- i_arb_mem_addr  in  32  data address.
- i_arb_mem_wdata  in  32  store data.
- i_arb_mem_be  in  4  byte enables.
- o_arb_mem_rvalid  out  1  load data valid / store acknowledge (one-cycle pulse).
- o_arb_mem_rdata  out  32  load data; 0 for stores.
- o_arb_stall_mem  out  1  i_arb_mem_req && !o_arb_mem_rvalid; freezes IF..MEM.
- o_arb_bus_req, o_arb_bus_we  out  1  bus address-phase request and write flag.
- o_arb_bus_addr, o_arb_bus_wdata  out  32  registered address and write data.
- o_arb_bus_be  out  4  registered byte enables; 4'hF for fetches.
- i_arb_bus_gnt  in  1  bus accepts the address phase.
- i_arb_bus_rvalid  in  1  bus response.
- i_arb_bus_rdata  in  32  bus read data.
- o_arb_timeout  out  1  one-cycle pulse when a data phase times out.

## Operation
- FSM states: IDLE, ADDR_IF, ADDR_MEM, DATA_IF, DATA_MEM. Reset state is IDLE.
- IDLE:
  - If i_arb_mem_req, latch the MEM request into the bus registers and go to ADDR_MEM.
  - Else if i_arb_if_req && !i_arb_if_flush, latch the IF request (we=0, be=4'hF) and go to ADDR_IF.
  - Else stay in IDLE.
- ADDR_x:
  - o_arb_bus_req=1, driven from the latched registers, held stable until i_arb_bus_gnt.
  - On gnt, go to DATA_x and clear the timeout counter.
- DATA_x:
  - Wait for i_arb_bus_rvalid.
  - DATA_MEM: o_arb_mem_rvalid = i_arb_bus_rvalid; rdata is passed through combinationally (0 when the latched we=1). On rvalid, go to IDLE.
  - DATA_IF: o_arb_if_rvalid = i_arb_bus_rvalid && !drop. On rvalid, go to IDLE.
- Flush:
  - i_arb_if_flush in ADDR_IF or DATA_IF sets the drop flag.
  - The transaction still completes on the bus, but its response is never forwarded.
  - drop clears on return to IDLE.
  - A flush coincident with rvalid also suppresses that response.
- Timeout:
  - An 8-bit (sized to TIMEOUT_CYC) counter increments each DATA_x cycle without rvalid.
  - When it reaches TIMEOUT_CYC: pulse o_arb_timeout, complete the owner with rvalid=1 and rdata=0 (suppressed if drop), and go to IDLE.
  - ADDR_x has no timeout.
- Simultaneous IF and MEM requests in IDLE: MEM wins. IF waits, stalled, and MEM cannot starve it indefinitely because each instruction issues at most one data access.
- Requesters change req/addr only after their rvalid. The arbiter ignores request inputs outside IDLE.

## Timing
- Reset values:
  - state=IDLE, drop=0, counter=0.
  - All bus registers 0; o_arb_bus_req=0.
  - All rvalid and o_arb_timeout outputs 0.
- Zero-wait bus (gnt in the first ADDR cycle, rvalid one cycle later):
  - Request sampled at cycle N, bus_req high at N+1, rvalid pulse at N+2, IDLE at N+3.
  - Result: 3-cycle access, with a new request accepted at N+3.
- Stall outputs are combinational. They drop in the same cycle as the owner's rvalid.
- Reset asserted mid-transaction returns everything to IDLE immediately. The bus is reset by the same i_rst.

## Structure
- rv_pkg gains arb_state_e (the five states).
- No sub-module; the timeout counter is inline.

## Test plan
- IF-only fetch with zero-wait bus:
  - Stimulus: i_arb_if_addr=0x100 at cycle 0, rdata=0x00500093.
  - Required: bus_req at cycle 1 with addr=0x100 and be=4'hF; o_arb_if_rvalid and rdata=0x00500093 at cycle 2; stall_if=1 in cycles 0–1.
- Simultaneous IF (0x104) and MEM store (0x2000, wdata=0xDEADBEEF, be=4'b0011):
  - Required: the store is issued first with we=1 and be=4'b0011; o_arb_mem_rvalid with rdata=0; the fetch is issued in the following IDLE cycle.
- Gnt delayed 3 cycles on a load from 0x3000:
  - Required: addr/be stable and bus_req held for all 4 ADDR cycles.
  - Then rvalid returns rdata=0x12345678 to o_arb_mem_rdata.
- Flush during DATA_IF:
  - Required: o_arb_if_rvalid stays 0 when the bus rvalid arrives, and the state returns to IDLE.
  - A new fetch at 0x200 then completes normally.
- TIMEOUT_CYC=4 and the bus never returns rvalid:
  - Required: o_arb_timeout and o_arb_mem_rvalid pulse together with rdata=0 on the 4th DATA cycle; stall_mem releases.
- i_rst asserted in DATA_MEM:
  - Required: all outputs read 0 while reset is held; no rvalid appears after release.
